// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control FSM (IF/ID/EXE/MEM/WB/HALT). It sequences one instruction
// over 2-5 cycles and drives the shared datapath strobes.
// The instruction class and the ALU operation are captured once in ID. From EXE
// to the last cycle of the instruction, the operand/ALU strobes are driven from
// that captured copy, so they stay stable until WB.
// Optional feature: define MCTRL_MEM_WAIT_EN to make IF and MEM wait for
// mem_ready. Without it, mem_ready is ignored and IF/MEM last one cycle.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int                OP_W    = 6,
    parameter int                FUNCT_W = 6,
    parameter int                ALUC_W  = 4,
    parameter logic [OP_W-1:0]   HALT_OP = 6'b111111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWre,
    output logic                 IRWre,
    output logic                 ALUSrcB,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 ExtSel,
    output logic                 RegDst,
    output logic                 PCSrc,
    output logic                 jump,
    output logic [ALUC_W-1:0]    ALUControl,
    output logic [2:0]           state_o,
    output logic                 instr_done,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_NONE = 4'd0,
        CL_R    = 4'd1,
        CL_ADDI = 4'd2,
        CL_ORI  = 4'd3,
        CL_LW   = 4'd4,
        CL_SW   = 4'd5,
        CL_BEQ  = 4'd6,
        CL_J    = 4'd7,
        CL_HALT = 4'd8,
        CL_ILL  = 4'd9
    } class_t;

    localparam logic [OP_W-1:0]    OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0]    OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0]    OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0]    OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0]    OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0]    OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0]    OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT   = 6'b101010;

    localparam logic [ALUC_W-1:0]  ALU_ADD  = ALUC_W'(3'd0);
    localparam logic [ALUC_W-1:0]  ALU_SUB  = ALUC_W'(3'd1);
    localparam logic [ALUC_W-1:0]  ALU_AND  = ALUC_W'(3'd2);
    localparam logic [ALUC_W-1:0]  ALU_OR   = ALUC_W'(3'd3);
    localparam logic [ALUC_W-1:0]  ALU_SLT  = ALUC_W'(3'd4);

    // Classify the opcode/funct pair in the IR. HALT_OP is checked first so
    // that it is never mistaken for another opcode.
    function automatic class_t decodeClass(input logic [OP_W-1:0] opIn,
                                           input logic [FUNCT_W-1:0] fnIn);
        class_t cls;
        if (opIn == HALT_OP) begin
            cls = CL_HALT;
        end else begin
            case (opIn)
                OP_RTYPE: begin
                    case (fnIn)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls = CL_R;
                        default:                               cls = CL_ILL;
                    endcase
                end
                OP_ADDI: cls = CL_ADDI;
                OP_ORI:  cls = CL_ORI;
                OP_LW:   cls = CL_LW;
                OP_SW:   cls = CL_SW;
                OP_BEQ:  cls = CL_BEQ;
                OP_J:    cls = CL_J;
                default: cls = CL_ILL;
            endcase
        end
        return cls;
    endfunction

    // Select the ALU operation for the opcode/funct pair.
    // Loads/stores use add for the address calculation and beq uses sub for
    // the compare.
    function automatic logic [ALUC_W-1:0] decodeAlu(input logic [OP_W-1:0] opIn,
                                                    input logic [FUNCT_W-1:0] fnIn);
        logic [ALUC_W-1:0] alu;
        case (opIn)
            OP_RTYPE: begin
                case (fnIn)
                    FN_SUB:  alu = ALU_SUB;
                    FN_AND:  alu = ALU_AND;
                    FN_OR:   alu = ALU_OR;
                    FN_SLT:  alu = ALU_SLT;
                    default: alu = ALU_ADD;
                endcase
            end
            OP_ORI:  alu = ALU_OR;
            OP_BEQ:  alu = ALU_SUB;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

    state_t            state_r;
    state_t            nextState_s;
    class_t            instrClass_r;
    logic [ALUC_W-1:0] aluOp_r;
    class_t            idClass_s;
    logic [ALUC_W-1:0] idAlu_s;
    logic              memGo_s;
    logic              holdStrobes_s;

    assign idClass_s = decodeClass(op, funct);
    assign idAlu_s   = decodeAlu(op, funct);

`ifdef MCTRL_MEM_WAIT_EN
    assign memGo_s = mem_ready;
`else
    logic unusedMemReady_s;
    assign unusedMemReady_s = mem_ready;
    assign memGo_s          = 1'b1;
`endif

    // The FSM state register. Reset returns to IF and abandons any in-flight
    // instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Capture the decoded instruction once in ID. This copy feeds the
    // EXE..WB strobes, so they do not move even if op changes afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrClass_r <= CL_NONE;
            aluOp_r      <= ALU_ADD;
        end else if (state_r == S_ID) begin
            instrClass_r <= idClass_s;
            aluOp_r      <= idAlu_s;
        end else begin
            instrClass_r <= instrClass_r;
            aluOp_r      <= aluOp_r;
        end
    end

    // Compute the next state and the datapath strobes from the current state
    // and the instruction.
    always_comb begin
        nextState_s   = state_r;
        PCWre         = 1'b0;
        IRWre         = 1'b0;
        ALUSrcB       = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        MemWrite      = 1'b0;
        ExtSel        = 1'b0;
        RegDst        = 1'b0;
        PCSrc         = 1'b0;
        jump          = 1'b0;
        ALUControl    = ALU_ADD;
        illegal       = 1'b0;
        holdStrobes_s = 1'b0;

        case (state_r)
            S_IF: begin
                IRWre = 1'b1;
                if (memGo_s) begin
                    nextState_s = S_ID;
                end else begin
                    nextState_s = S_IF;
                end
            end
            S_ID: begin
                case (idClass_s)
                    CL_J: begin
                        jump        = 1'b1;
                        PCWre       = 1'b1;
                        nextState_s = S_IF;
                    end
                    CL_HALT: begin
                        nextState_s = S_HALT;
                    end
                    CL_ILL: begin
                        illegal     = 1'b1;
                        PCWre       = 1'b1;
                        nextState_s = S_IF;
                    end
                    default: begin
                        nextState_s = S_EXE;
                    end
                endcase
            end
            S_EXE: begin
                holdStrobes_s = 1'b1;
                if (instrClass_r == CL_BEQ) begin
                    PCSrc       = zero;
                    PCWre       = 1'b1;
                    nextState_s = S_IF;
                end else if ((instrClass_r == CL_LW) || (instrClass_r == CL_SW)) begin
                    nextState_s = S_MEM;
                end else begin
                    nextState_s = S_WB;
                end
            end
            S_MEM: begin
                holdStrobes_s = 1'b1;
                if (instrClass_r == CL_SW) begin
                    MemWrite = 1'b1;
                    if (memGo_s) begin
                        PCWre       = 1'b1;
                        nextState_s = S_IF;
                    end else begin
                        nextState_s = S_MEM;
                    end
                end else begin
                    if (memGo_s) begin
                        nextState_s = S_WB;
                    end else begin
                        nextState_s = S_MEM;
                    end
                end
            end
            S_WB: begin
                holdStrobes_s = 1'b1;
                RegWrite      = 1'b1;
                PCWre         = 1'b1;
                nextState_s   = S_IF;
            end
            S_HALT: begin
                nextState_s = S_HALT;
            end
            default: begin
                nextState_s = S_IF;
            end
        endcase

        if (holdStrobes_s) begin
            ALUControl = aluOp_r;
            ALUSrcB    = (instrClass_r == CL_ADDI) || (instrClass_r == CL_ORI) ||
                         (instrClass_r == CL_LW)   || (instrClass_r == CL_SW);
            ExtSel     = (instrClass_r != CL_ORI);
            RegDst     = (instrClass_r == CL_R);
            MemtoReg   = (instrClass_r == CL_LW);
        end else begin
            ALUControl = ALU_ADD;
        end
    end

    assign state_o    = state_r;
    assign instr_done = PCWre;

endmodule
